// File: rtl/cabac_ctx_rmw_pkg.sv
// Shared types, constants and the LPS state-transition table for the
// CABAC context-memory read-modify-write stage.
package cabac_ctx_pkg;

  // Context word is {mps, pStateIdx[5:0]}.
  localparam int CTX_W = 7;
  localparam int MPS_BIT = 6;
  localparam int STATE_W = 6;

  // Highest state reachable through an MPS step.
  localparam logic [STATE_W-1:0] STATE_MPS_MAX = 6'd62;

  // Next probability state after coding a least-probable symbol.
  function automatic logic [STATE_W-1:0] trans_idx_lps(input logic [STATE_W-1:0] state);
    logic [STATE_W-1:0] nxt;
    case (state)
      6'd0, 6'd1:               nxt = 6'd0;
      6'd2:                     nxt = 6'd1;
      6'd3, 6'd4:               nxt = 6'd2;
      6'd5, 6'd6:               nxt = 6'd4;
      6'd7:                     nxt = 6'd5;
      6'd8:                     nxt = 6'd6;
      6'd9:                     nxt = 6'd7;
      6'd10:                    nxt = 6'd8;
      6'd11, 6'd12:             nxt = 6'd9;
      6'd13, 6'd14:             nxt = 6'd11;
      6'd15:                    nxt = 6'd12;
      6'd16, 6'd17:             nxt = 6'd13;
      6'd18, 6'd19:             nxt = 6'd15;
      6'd20, 6'd21:             nxt = 6'd16;
      6'd22, 6'd23:             nxt = 6'd18;
      6'd24, 6'd25:             nxt = 6'd19;
      6'd26, 6'd27:             nxt = 6'd21;
      6'd28, 6'd29:             nxt = 6'd22;
      6'd30:                    nxt = 6'd23;
      6'd31, 6'd32:             nxt = 6'd24;
      6'd33:                    nxt = 6'd25;
      6'd34, 6'd35:             nxt = 6'd26;
      6'd36, 6'd37:             nxt = 6'd27;
      6'd38:                    nxt = 6'd28;
      6'd39, 6'd40:             nxt = 6'd29;
      6'd41, 6'd42, 6'd43:      nxt = 6'd30;
      6'd44:                    nxt = 6'd31;
      6'd45, 6'd46:             nxt = 6'd32;
      6'd47, 6'd48, 6'd49:      nxt = 6'd33;
      6'd50, 6'd51:             nxt = 6'd34;
      6'd52, 6'd53, 6'd54:      nxt = 6'd35;
      6'd55, 6'd56, 6'd57:      nxt = 6'd36;
      6'd58, 6'd59, 6'd60:      nxt = 6'd37;
      6'd61, 6'd62:             nxt = 6'd38;
      default:                  nxt = 6'd63;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cabac_ctx_rmw_if.sv
// Init, request and BAC-output signal bundle for the context RMW stage.
interface cabac_ctx_rmw_if #(
  parameter int CTX_AW = 8
);
  import cabac_ctx_pkg::*;

  logic              init_en;
  logic [CTX_AW-1:0] init_idx;
  logic [CTX_W-1:0]  init_data;

  logic              req_valid;
  logic              req_ready;
  logic [CTX_AW-1:0] req_idx;
  logic              req_bin_num;
  logic              req_sym_0;
  logic              req_sym_1;

  logic              out_valid;
  logic [CTX_AW-1:0] out_idx;
  logic [CTX_W-1:0]  out_ctx;
  logic              out_bin_num;
  logic              out_sym_0;
  logic              out_sym_1;

  // Producer of init/requests, consumer of the BAC-side outputs.
  modport master (
    output init_en, init_idx, init_data,
    output req_valid, req_idx, req_bin_num, req_sym_0, req_sym_1,
    input  req_ready,
    input  out_valid, out_idx, out_ctx, out_bin_num, out_sym_0, out_sym_1
  );

  // The RMW stage itself.
  modport slave (
    input  init_en, init_idx, init_data,
    input  req_valid, req_idx, req_bin_num, req_sym_0, req_sym_1,
    output req_ready,
    output out_valid, out_idx, out_ctx, out_bin_num, out_sym_0, out_sym_1
  );
endinterface

// File: rtl/cabac_ucontext_t.sv
// Combinational single-symbol context update (HEVC state transition).
module cabac_ucontext_t
  import cabac_ctx_pkg::*;
(
  input  logic [CTX_W-1:0] in_context,
  input  logic             symbol,
  output logic [CTX_W-1:0] out_context
);

  logic               mps;
  logic [STATE_W-1:0] state;

  assign mps   = in_context[MPS_BIT];
  assign state = in_context[STATE_W-1:0];

  // MPS steps the state up (saturating); LPS follows the LPS table and flips mps at state 0.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    out_context = in_context;
    if (symbol == mps) begin
      out_context[STATE_W-1:0] = (state >= STATE_MPS_MAX) ? STATE_MPS_MAX : state + 6'd1;
    end else begin
      out_context[MPS_BIT]     = (state == 6'd0) ? ~mps : mps;
      out_context[STATE_W-1:0] = trans_idx_lps(state);
    end
  end

endmodule

// File: rtl/cabac_ucontext_tt.sv
// Two-symbol context update: symbol_0 is applied first, then symbol_1.
module cabac_ucontext_tt
  import cabac_ctx_pkg::*;
(
  input  logic [CTX_W-1:0] in_context,
  input  logic             symbol_0,
  input  logic             symbol_1,
  output logic [CTX_W-1:0] out_context
);

  logic [CTX_W-1:0] mid_context;

  cabac_ucontext_t u_first (
    .in_context (in_context),
    .symbol     (symbol_0),
    .out_context(mid_context)
  );

  cabac_ucontext_t u_second (
    .in_context (mid_context),
    .symbol     (symbol_1),
    .out_context(out_context)
  );

endmodule

// File: rtl/cabac_ctx_rmw.sv
// CABAC context memory with a one-cycle read-modify-write pipeline.
// S0 reads the context, S1 presents the pre-update value to the BAC and
// writes the updated value back; back-to-back same-index requests forward
// the just-computed value instead of the stale memory word.
module cabac_ctx_rmw
  import cabac_ctx_pkg::*;
#(
  parameter int CTX_NUM = 256,
  parameter int CTX_AW  = 8
) (
  input logic               clk,
  input logic               rst,
  cabac_ctx_rmw_if.slave    bus
);

  logic [CTX_W-1:0]  mem [CTX_NUM];

  logic              accept;
  logic              s1_valid;
  logic [CTX_AW-1:0] s1_idx;
  logic              s1_bin_num;
  logic              s1_sym_0;
  logic              s1_sym_1;
  logic              fwd;
  logic [CTX_W-1:0]  mem_rd_q;
  logic [CTX_W-1:0]  wb_data_q;

  logic [CTX_W-1:0]  cur_ctx;
  logic [CTX_W-1:0]  one_bin_ctx;
  logic [CTX_W-1:0]  two_bin_ctx;
  logic [CTX_W-1:0]  new_ctx;

  function automatic logic idx_in_range(input logic [CTX_AW-1:0] idx);
    return 32'(idx) < CTX_NUM;
  endfunction

  // Init owns the memory port, so requests stall while it is active.
  assign bus.req_ready = ~bus.init_en;
  assign accept        = bus.req_valid & ~bus.init_en;

  assign cur_ctx = fwd ? wb_data_q : mem_rd_q;

  cabac_ucontext_t u_one_bin (
    .in_context (cur_ctx),
    .symbol     (s1_sym_0),
    .out_context(one_bin_ctx)
  );

  cabac_ucontext_tt u_two_bin (
    .in_context (cur_ctx),
    .symbol_0   (s1_sym_0),
    .symbol_1   (s1_sym_1),
    .out_context(two_bin_ctx)
  );

  assign new_ctx = s1_bin_num ? two_bin_ctx : one_bin_ctx;

  // S0 -> S1 capture, memory read register, forward flag and write-back register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      s1_bin_num <= 1'b0;
      s1_sym_0   <= 1'b0;
      s1_sym_1   <= 1'b0;
      fwd        <= 1'b0;
      mem_rd_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      s1_valid <= accept;
      fwd      <= accept && s1_valid && (s1_idx == bus.req_idx);
      if (accept) begin
        s1_idx     <= bus.req_idx;
        s1_bin_num <= bus.req_bin_num;
        s1_sym_0   <= bus.req_sym_0;
        s1_sym_1   <= bus.req_sym_1;
        mem_rd_q   <= mem[bus.req_idx];
      end
      if (s1_valid) begin
        wb_data_q <= new_ctx;
      end
    end
  end

  // Single write port: init wins over the S1 write-back; out-of-range indices are dropped.
  // NOTE: the memory array has no reset; its contents are defined only by init writes.
  always_ff @(posedge clk) begin
    if (bus.init_en) begin
      if (idx_in_range(bus.init_idx)) begin
        mem[bus.init_idx] <= bus.init_data;
      end
    end else if (s1_valid && idx_in_range(s1_idx)) begin
      mem[s1_idx] <= new_ctx;
    end
  end

  assign bus.out_valid   = s1_valid;
  assign bus.out_idx     = s1_idx;
  assign bus.out_ctx     = cur_ctx;
  assign bus.out_bin_num = s1_bin_num;
  assign bus.out_sym_0   = s1_sym_0;
  assign bus.out_sym_1   = s1_sym_1;

endmodule

// File: tb/tb_cabac_ctx_rmw.sv
// Directed bench for the CABAC context RMW stage.
module tb_cabac_ctx_rmw;

  logic clk = 1'b0;
  logic rst;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cabac_ctx_rmw_if #(.CTX_AW(8)) bus ();

  cabac_ctx_rmw #(
    .CTX_NUM(256),
    .CTX_AW (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [7:0] idx, input logic [6:0] data);
    bus.init_en   = 1'b1;
    bus.init_idx  = idx;
    bus.init_data = data;
    tick();
    bus.init_en = 1'b0;
  endtask

  // One accepted request, then check the S1 outputs in the following cycle.
  task automatic do_req(input string tag, input logic [7:0] idx, input logic bn,
                        input logic s0, input logic s1, input logic [6:0] exp_ctx);
    bus.req_valid   = 1'b1;
    bus.req_idx     = idx;
    bus.req_bin_num = bn;
    bus.req_sym_0   = s0;
    bus.req_sym_1   = s1;
    tick();
    bus.req_valid = 1'b0;
    check({tag, ".valid"}, {7'd0, bus.out_valid}, 8'h01);
    check({tag, ".idx"}, bus.out_idx, idx);
    check({tag, ".ctx"}, {1'b0, bus.out_ctx}, {1'b0, exp_ctx});
  endtask

  initial begin
    rst             = 1'b1;
    bus.init_en     = 1'b0;
    bus.init_idx    = '0;
    bus.init_data   = '0;
    bus.req_valid   = 1'b0;
    bus.req_idx     = '0;
    bus.req_bin_num = 1'b0;
    bus.req_sym_0   = 1'b0;
    bus.req_sym_1   = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst.out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst.out_idx", bus.out_idx, 8'h00);
    check("rst.out_ctx", {1'b0, bus.out_ctx}, 8'h00);
    check("rst.echo", {5'd0, bus.out_bin_num, bus.out_sym_0, bus.out_sym_1}, 8'h00);
    rst = 1'b0;
    tick();

    // Single-bin MPS hit: state 10 -> 11.
    do_init(8'd5, 7'h0A);
    do_req("mps1", 8'd5, 1'b0, 1'b0, 1'b0, 7'h0A);
    check("mps1.bin_num", {7'd0, bus.out_bin_num}, 8'h00);
    tick();
    check("idle.out_valid", {7'd0, bus.out_valid}, 8'h00);
    do_req("mps1.rd", 8'd5, 1'b0, 1'b0, 1'b0, 7'h0B);
    tick();

    // LPS at state 0 flips mps: 0x40 -> 0x00.
    do_init(8'd3, 7'h40);
    do_req("lps0", 8'd3, 1'b0, 1'b0, 1'b0, 7'h40);
    tick();
    do_req("lps0.rd", 8'd3, 1'b0, 1'b1, 1'b0, 7'h00);
    tick();

    // LPS mid-table: state 30 mps 0, sym 1 -> state 23.
    do_init(8'd11, 7'h1E);
    do_req("lps30", 8'd11, 1'b0, 1'b1, 1'b0, 7'h1E);
    tick();
    do_req("lps30.rd", 8'd11, 1'b0, 1'b0, 1'b0, 7'h17);
    tick();

    // MPS saturation at 62.
    do_init(8'd12, 7'h7E);
    do_req("sat", 8'd12, 1'b0, 1'b1, 1'b0, 7'h7E);
    tick();
    do_req("sat.rd", 8'd12, 1'b0, 1'b0, 1'b0, 7'h7E);
    tick();

    // Two-bin LPS,LPS: state 20 -> 16 -> 13.
    do_init(8'd7, 7'h14);
    do_req("two", 8'd7, 1'b1, 1'b1, 1'b1, 7'h14);
    check("two.echo", {5'd0, bus.out_bin_num, bus.out_sym_0, bus.out_sym_1}, 8'h07);
    tick();
    do_req("two.rd", 8'd7, 1'b0, 1'b0, 1'b0, 7'h0D);
    tick();

    // Two-bin MPS,LPS: state 5 -> 6 -> 4.
    do_init(8'd13, 7'h05);
    do_req("two_ml", 8'd13, 1'b1, 1'b0, 1'b1, 7'h05);
    tick();
    do_req("two_ml.rd", 8'd13, 1'b0, 1'b0, 1'b0, 7'h04);
    tick();

    // Two-bin at state 0 mps 1, bins (0,0): LPS flips to mps 0, then MPS -> state 1.
    do_init(8'd14, 7'h40);
    do_req("two_flip", 8'd14, 1'b1, 1'b0, 1'b0, 7'h40);
    tick();
    do_req("two_flip.rd", 8'd14, 1'b0, 1'b1, 1'b0, 7'h01);
    tick();

    // Back-to-back forwarding on idx 9.
    do_init(8'd9, 7'h00);
    bus.req_valid   = 1'b1;
    bus.req_idx     = 8'd9;
    bus.req_bin_num = 1'b0;
    bus.req_sym_0   = 1'b0;
    bus.req_sym_1   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b.valid%0d", i), {7'd0, bus.out_valid}, 8'h01);
      check($sformatf("b2b.ctx%0d", i), {1'b0, bus.out_ctx}, 8'(i));
    end
    bus.req_valid = 1'b0;
    tick();
    do_req("b2b.rd", 8'd9, 1'b0, 1'b0, 1'b0, 7'h04);
    tick();

    // Init priority: request stalls while init_en is high, then sees the init value.
    bus.init_en     = 1'b1;
    bus.init_idx    = 8'd20;
    bus.init_data   = 7'h33;
    bus.req_valid   = 1'b1;
    bus.req_idx     = 8'd20;
    bus.req_bin_num = 1'b0;
    bus.req_sym_0   = 1'b0;
    bus.req_sym_1   = 1'b0;
    #1;
    check("prio.ready_lo", {7'd0, bus.req_ready}, 8'h00);
    tick();
    check("prio.no_valid", {7'd0, bus.out_valid}, 8'h00);
    bus.init_en = 1'b0;
    #1;
    check("prio.ready_hi", {7'd0, bus.req_ready}, 8'h01);
    tick();
    bus.req_valid = 1'b0;
    check("prio.valid", {7'd0, bus.out_valid}, 8'h01);
    check("prio.ctx", {1'b0, bus.out_ctx}, 8'h33);
    tick();

    // Async reset between accept and write-back: output drops, write is discarded.
    do_init(8'd25, 7'h10);
    do_req("arst", 8'd25, 1'b0, 1'b0, 1'b0, 7'h10);
    #1;
    rst = 1'b1;
    #1;
    check("arst.valid_drop", {7'd0, bus.out_valid}, 8'h00);
    check("arst.ctx_clr", {1'b0, bus.out_ctx}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    do_req("arst.rd", 8'd25, 1'b0, 1'b0, 1'b0, 7'h10);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
